// File: rtl/piano_tone_ctrl.sv
// piano_tone_ctrl: maps debounced piano keys to a tone divisor with minimum note hold and inter-note gap
module piano_tone_ctrl #(
    parameter int CLK_HZ      = 12000000,
    parameter int HOLD_CYCLES = 1200000,
    parameter int GAP_CYCLES  = 120000
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        play_en,
    input  logic [7:0]  key,
    output logic [31:0] freq,
    output logic        pwm_en,
    output logic [2:0]  note_idx,
    output logic        busy
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] PLAY = 2'd1;
    localparam logic [1:0] GAP  = 2'd2;
    localparam int HW = HOLD_CYCLES > 1 ? $clog2(HOLD_CYCLES) : 1;
    localparam int GW = GAP_CYCLES > 1 ? $clog2(GAP_CYCLES) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CYCLES - 1);
    // Divisors for C4..C5, resolved at elaboration
    localparam logic [31:0] DIV [8] = '{
        32'(CLK_HZ / 262 - 1), 32'(CLK_HZ / 294 - 1),
        32'(CLK_HZ / 330 - 1), 32'(CLK_HZ / 349 - 1),
        32'(CLK_HZ / 392 - 1), 32'(CLK_HZ / 440 - 1),
        32'(CLK_HZ / 494 - 1), 32'(CLK_HZ / 523 - 1)
    };

    logic [1:0]    state;
    logic [HW-1:0] hold_cnt;
    logic [GW-1:0] gap_cnt;
    logic [2:0]    win;
    logic          released;

    // Priority encoder: highest pressed key wins
    always_comb begin
        win = '0;
        for (int i = 0; i < 8; i++) if (key[i]) win = 3'(i);
    end

    assign released = !key[note_idx] || win != note_idx;

    // Note sequencer: IDLE -> PLAY (min hold) -> GAP -> IDLE; play_en low aborts to IDLE
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state    <= IDLE;
            freq     <= '0;
            pwm_en   <= 1'b0;
            note_idx <= '0;
            busy     <= 1'b0;
            hold_cnt <= '0;
            gap_cnt  <= '0;
        end else if (!play_en) begin
            state  <= IDLE;
            pwm_en <= 1'b0;
            busy   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (key != 8'd0) begin
                    state    <= PLAY;
                    note_idx <= win;
                    freq     <= DIV[win];
                    pwm_en   <= 1'b1;
                    busy     <= 1'b1;
                    hold_cnt <= '0;
                end
                PLAY: if (hold_cnt == HOLD_LAST && released) begin
                    state   <= GAP;
                    pwm_en  <= 1'b0;
                    gap_cnt <= '0;
                end else begin
                    hold_cnt <= hold_cnt == HOLD_LAST ? hold_cnt : hold_cnt + 1'b1;
                end
                GAP: if (gap_cnt == GAP_LAST) begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end else begin
                    gap_cnt <= gap_cnt + 1'b1;
                end
                default: begin
                    state  <= IDLE;
                    pwm_en <= 1'b0;
                    busy   <= 1'b0;
                end
            endcase
        end
    end
endmodule
